// File: rtl/inst_fetcher.sv
// Instruction fetch front end: walks a fetch PC, runs one memory word fetch at a time,
// and queues returned words with their PCs for the decoder, with redirect flushing.
module inst_fetcher #(
    parameter int          QUEUE_ADDR_W = 2,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ifetch_req,
    output logic [31:0] ifetch_addr,
    input  logic        ifetch_done,
    input  logic [31:0] ifetch_data,
    input  logic        jump_en,
    input  logic [31:0] jump_pc,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int DEPTH = 2 ** QUEUE_ADDR_W;
    localparam logic [QUEUE_ADDR_W:0] DEPTH_CNT = (QUEUE_ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t                  state;
    logic [31:0]             fetch_pc;
    logic [31:0]             word_mem [DEPTH];
    logic [31:0]             pc_mem   [DEPTH];
    logic [QUEUE_ADDR_W-1:0] head;
    logic [QUEUE_ADDR_W-1:0] tail;
    logic [QUEUE_ADDR_W:0]   count;
    logic                    push;
    logic                    pop;
    logic [31:0]             jump_target;

    assign jump_target = {jump_pc[31:2], 2'b00};
    assign push        = rdy_in & ~jump_en & (state == WAIT) & ifetch_done;
    assign inst_valid  = (count != '0) & ~jump_en;
    assign pop         = inst_valid & inst_ready & rdy_in;
    assign inst_out    = word_mem[head];
    assign inst_pc     = pc_mem[head];

    // A new request only starts when a slot is free now, so the single
    // outstanding word always has room when it returns.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            ifetch_req  <= 1'b0;
            ifetch_addr <= '0;
        end else if (rdy_in) begin
            if (jump_en) begin
                fetch_pc <= jump_target;
            end
            case (state)
                IDLE: begin
                    if (!jump_en && count < DEPTH_CNT) begin
                        state       <= WAIT;
                        ifetch_req  <= 1'b1;
                        ifetch_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (ifetch_done) begin
                        state      <= IDLE;
                        ifetch_req <= 1'b0;
                        if (!jump_en) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end else if (jump_en) begin
                        state      <= DISCARD;
                        ifetch_req <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (ifetch_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ifetch_req <= 1'b0;
                end
            endcase
        end
    end

    // Entry storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (jump_en) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    word_mem[tail] <= ifetch_data;
                    pc_mem[tail]   <= fetch_pc;
                    tail           <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
